// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the unified SRAM port arbiter.
package mem_arb_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 32;
    localparam int BE_W       = 4;

    typedef enum logic [0:0] {
        BOOT = 1'b0,
        RUN  = 1'b1
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous SRAM between the boot loader, the CPU
// fetch port and the CPU data port. Fetch gets priority only after it has
// been denied STARVE_LIMIT cycles in a row; read returns are steered by a
// one-cycle owner tag since the SRAM has fixed 1-cycle read latency.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   BOOT  | reset state; only loader writes reach the SRAM, no grants
//   RUN   | fetch/data arbitration; left only through reset
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    input  logic [DATA_W-1:0] ld_wdata,
    input  logic              ld_done,
    output logic              boot_busy,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              dm_req,
    input  logic [BE_W-1:0]   dm_w_en,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_write_data,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [DATA_W-1:0] dm_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [BE_W-1:0]   mem_w_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam logic [0:0] ST_BOOT = BOOT;
    localparam logic [0:0] ST_RUN  = RUN;
    localparam logic [3:0] LIMIT   = 4'(STARVE_LIMIT);

    logic [0:0] state;
    logic [3:0] starve_cnt;
    owner_t     owner;
    owner_t     owner_nxt;
    logic       in_run;
    logic       if_pri;

    assign in_run    = (state == ST_RUN);
    assign boot_busy = (state == ST_BOOT);
    assign if_pri    = (starve_cnt >= LIMIT);

    // Grant decision: data port wins unless fetch has been starved long enough
    always_comb begin
        if_gnt = 1'b0;
        dm_gnt = 1'b0;
        if (in_run) begin
            if (if_req && (!dm_req || if_pri)) begin
                if_gnt = 1'b1;
            end else if (dm_req) begin
                dm_gnt = 1'b1;
            end
        end
    end

    // SRAM port mux; an idle cycle drives all zeros so nothing is written
    always_comb begin
        mem_addr       = '0;
        mem_w_en       = '0;
        mem_write_data = '0;
        if (state == ST_BOOT) begin
            if (ld_req) begin
                mem_addr       = ld_addr;
                mem_w_en       = '1;
                mem_write_data = ld_wdata;
            end
        end else if (dm_gnt) begin
            mem_addr       = dm_addr;
            mem_w_en       = dm_w_en;
            mem_write_data = dm_write_data;
        end else if (if_gnt) begin
            mem_addr = if_addr;
        end
    end

    // Tag each granted read so its return is steered next cycle
    always_comb begin
        owner_nxt = OWN_NONE;
        if (if_gnt) begin
            owner_nxt = OWN_IF;
        end else if (dm_gnt && (dm_w_en == '0)) begin
            owner_nxt = OWN_DM;
        end
    end

    // Boot/run state: ld_done only matters in BOOT, reset is the only way back
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_BOOT;
        end else if ((state == ST_BOOT) && ld_done) begin
            state <= ST_RUN;
        end
    end

    // Saturating count of consecutive cycles a pending fetch was refused
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt <= '0;
        end else if (!in_run || !if_req || if_gnt) begin
            starve_cnt <= '0;
        end else if (starve_cnt != 4'hF) begin
            starve_cnt <= starve_cnt + 4'd1;
        end
    end

    // Owner tag register; async clear drops any in-flight read on reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            owner <= OWN_NONE;
        end else begin
            owner <= owner_nxt;
        end
    end

    assign if_rvalid = (owner == OWN_IF);
    assign dm_rvalid = (owner == OWN_DM);
    assign if_rdata  = mem_read_data;
    assign dm_rdata  = mem_read_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a behavioural SRAM and a
// scoreboard of expected read returns.
module tb_mem_port_arbiter;

    localparam int AW = 16;
    localparam int DW = 32;

    typedef struct {
        logic          is_if;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req;
    logic [AW-1:0] ld_addr;
    logic [DW-1:0] ld_wdata;
    logic          ld_done;
    logic          boot_busy;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic          if_gnt;
    logic          if_rvalid;
    logic [DW-1:0] if_rdata;
    logic          dm_req;
    logic [3:0]    dm_w_en;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_write_data;
    logic          dm_gnt;
    logic          dm_rvalid;
    logic [DW-1:0] dm_rdata;
    logic [AW-1:0] mem_addr;
    logic [3:0]    mem_w_en;
    logic [DW-1:0] mem_write_data;
    logic [DW-1:0] mem_read_data;

    logic [DW-1:0] sram    [256];
    logic [DW-1:0] ref_mem [256];
    exp_t          exp_q[$];
    int            n_chk = 0;
    int            n_err = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .ld_req        (ld_req),
        .ld_addr       (ld_addr),
        .ld_wdata      (ld_wdata),
        .ld_done       (ld_done),
        .boot_busy     (boot_busy),
        .if_req        (if_req),
        .if_addr       (if_addr),
        .if_gnt        (if_gnt),
        .if_rvalid     (if_rvalid),
        .if_rdata      (if_rdata),
        .dm_req        (dm_req),
        .dm_w_en       (dm_w_en),
        .dm_addr       (dm_addr),
        .dm_write_data (dm_write_data),
        .dm_gnt        (dm_gnt),
        .dm_rvalid     (dm_rvalid),
        .dm_rdata      (dm_rdata),
        .mem_addr      (mem_addr),
        .mem_w_en      (mem_w_en),
        .mem_write_data(mem_write_data),
        .mem_read_data (mem_read_data)
    );

    // Behavioural SRAM: byte-enable write, registered read
    always @(posedge clk) begin
        for (int b = 0; b < 4; b++) begin
            if (mem_w_en[b]) sram[mem_addr[9:2]][b*8 +: 8] <= mem_write_data[b*8 +: 8];
        end
        mem_read_data <= sram[mem_addr[9:2]];
    end

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic ref_write(input logic [AW-1:0] a, input logic [3:0] be, input logic [DW-1:0] d);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) ref_mem[a[9:2]][b*8 +: 8] = d[b*8 +: 8];
        end
    endtask

    task automatic push_exp(input logic is_if, input logic [AW-1:0] a);
        exp_t e;
        e.is_if = is_if;
        e.data  = ref_mem[a[9:2]];
        exp_q.push_back(e);
    endtask

    // Return monitor: every rvalid must match the oldest expected read
    always @(negedge clk) begin
        if (if_rvalid || dm_rvalid) begin
            chk("rv_both", {30'b0, if_rvalid & dm_rvalid}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("rv_unexp", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("rv_owner_if", {31'b0, if_rvalid}, {31'b0, e.is_if});
                chk("rv_data", if_rvalid ? if_rdata : dm_rdata, e.data);
            end
        end
    end

    initial begin
        logic [DW-1:0] ld_tab [2];
        ld_tab[0] = 32'h0000_0013;
        ld_tab[1] = 32'h0010_0073;
        for (int i = 0; i < 256; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        rst = 1'b1; ld_req = 0; ld_addr = '0; ld_wdata = '0; ld_done = 0;
        if_req = 0; if_addr = '0; dm_req = 0; dm_w_en = '0; dm_addr = '0; dm_write_data = '0;

        // Reset values
        @(negedge clk);
        chk("rst_boot_busy", {31'b0, boot_busy}, 32'd1);
        chk("rst_gnts", {30'b0, if_gnt, dm_gnt}, 32'd0);
        chk("rst_rvalids", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
        chk("rst_mem_addr", {16'b0, mem_addr}, 32'd0);
        chk("rst_mem_wen", {28'b0, mem_w_en}, 32'd0);
        chk("rst_mem_wdata", mem_write_data, 32'd0);
        next_cyc();
        rst = 1'b0;

        // Boot load with fetch requesting throughout
        if_req = 1; if_addr = 16'h0004;
        for (int i = 0; i < 2; i++) begin
            ld_req = 1; ld_addr = AW'(i * 4); ld_wdata = ld_tab[i];
            @(negedge clk);
            chk("boot_wen", {28'b0, mem_w_en}, 32'hF);
            chk("boot_addr", {16'b0, mem_addr}, i * 4);
            chk("boot_wdata", mem_write_data, ld_tab[i]);
            chk("boot_if_gnt", {31'b0, if_gnt}, 32'd0);
            ref_write(AW'(i * 4), 4'hF, ld_tab[i]);
            next_cyc();
        end
        ld_req = 0; ld_done = 1;
        @(negedge clk);
        chk("boot_busy_hold", {31'b0, boot_busy}, 32'd1);
        chk("boot_if_gnt_done", {31'b0, if_gnt}, 32'd0);
        next_cyc();
        ld_done = 0;

        // Fetch read alone in RUN
        @(negedge clk);
        chk("boot_busy_fall", {31'b0, boot_busy}, 32'd0);
        chk("fetch_gnt", {30'b0, if_gnt, dm_gnt}, 32'd2);
        chk("fetch_addr", {16'b0, mem_addr}, 32'h4);
        chk("fetch_wen", {28'b0, mem_w_en}, 32'd0);
        push_exp(1'b1, 16'h0004);
        next_cyc();
        if_req = 0;
        @(negedge clk);
        chk("fetch_rv", {30'b0, if_rvalid, dm_rvalid}, 32'd2);
        next_cyc();

        // Partial data write then read back
        dm_req = 1; dm_w_en = 4'b0011; dm_addr = 16'h0010; dm_write_data = 32'hAAAA_5555;
        @(negedge clk);
        chk("dw_gnt", {31'b0, dm_gnt}, 32'd1);
        chk("dw_wen", {28'b0, mem_w_en}, 32'h3);
        chk("dw_wdata", mem_write_data, 32'hAAAA_5555);
        ref_write(16'h0010, 4'b0011, 32'hAAAA_5555);
        next_cyc();
        dm_w_en = 4'b0000;
        @(negedge clk);
        chk("dw_no_rv", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
        chk("dr_gnt", {31'b0, dm_gnt}, 32'd1);
        chk("dr_exp_low", ref_mem[4], 32'h0000_5555);
        push_exp(1'b0, 16'h0010);
        next_cyc();
        dm_req = 0;
        next_cyc();

        // Contention: dm wins until fetch has starved STARVE_LIMIT cycles
        dm_req = 1; dm_w_en = 4'b0000; dm_addr = 16'h0010;
        if_req = 1; if_addr = 16'h0000;
        for (int k = 0; k < 7; k++) begin
            logic exp_if;
            exp_if = (k == 4);
            @(negedge clk);
            chk($sformatf("starve_gnt_%0d", k), {30'b0, if_gnt, dm_gnt}, exp_if ? 32'd2 : 32'd1);
            push_exp(exp_if, exp_if ? 16'h0000 : 16'h0010);
            next_cyc();
        end
        dm_req = 0; if_req = 0;
        next_cyc();
        next_cyc();

        // Reset while a fetch is in flight
        if_req = 1; if_addr = 16'h0004;
        @(negedge clk);
        chk("mid_gnt", {31'b0, if_gnt}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("mid_boot_busy", {31'b0, boot_busy}, 32'd1);
        chk("mid_rv", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
        @(posedge clk);
        #1;
        chk("mid_rv_after", {30'b0, if_rvalid, dm_rvalid}, 32'd0);
        rst = 1'b0; if_req = 0;
        @(negedge clk);
        chk("mid_still_boot", {31'b0, boot_busy}, 32'd1);
        next_cyc();

        // Loader write coinciding with ld_done
        ld_req = 1; ld_done = 1; ld_addr = 16'h0020; ld_wdata = 32'hCAFE_F00D;
        @(negedge clk);
        chk("ldd_wen", {28'b0, mem_w_en}, 32'hF);
        chk("ldd_addr", {16'b0, mem_addr}, 32'h20);
        ref_write(16'h0020, 4'hF, 32'hCAFE_F00D);
        next_cyc();
        ld_done = 0; ld_addr = 16'h0024; ld_wdata = 32'h1234_5678;
        @(negedge clk);
        chk("ldd_busy_fall", {31'b0, boot_busy}, 32'd0);
        chk("run_ld_wen", {28'b0, mem_w_en}, 32'd0);
        chk("run_ld_addr", {16'b0, mem_addr}, 32'd0);
        next_cyc();
        ld_req = 0; ld_done = 1;
        next_cyc();
        ld_done = 0;
        @(negedge clk);
        chk("run_ld_done_noeff", {31'b0, boot_busy}, 32'd0);
        next_cyc();

        // Read back both loader addresses
        dm_req = 1; dm_w_en = 4'b0000; dm_addr = 16'h0020;
        @(negedge clk);
        push_exp(1'b0, 16'h0020);
        next_cyc();
        dm_addr = 16'h0024;
        @(negedge clk);
        push_exp(1'b0, 16'h0024);
        next_cyc();
        dm_req = 0;
        for (int i = 0; i < 3; i++) next_cyc();

        chk("q_drain", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares one single-port synchronous SRAM (16-bit byte address, 32-bit data, 4-bit byte write enable, 1-cycle read latency) between three requesters:

- the boot program loader;
- the CPU instruction-fetch port;
- the CPU data-memory port.

It sits between `Top` and a unified `SRAM` instance, replacing the separate im/dm memories. It sequences boot-time loading, arbitrates fetch against data access with anti-starvation, and tags read returns.

## Interface

Parameters:

- `ADDR_W`, 16: address width, all ports.
- `DATA_W`, 32: data width.
- `STARVE_LIMIT`, 4: consecutive denied fetch cycles before fetch gets priority; legal range 1–15.

Ports:

- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `ld_req` in 1: loader write request (boot only).
- `ld_addr` in ADDR_W: loader address.
- `ld_wdata` in DATA_W: loader write data.
- `ld_done` in 1: single-cycle pulse ending boot.
- `boot_busy` out 1: high while in BOOT.
- `if_req` in 1: fetch read request.
- `if_addr` in ADDR_W: fetch address.
- `if_gnt` out 1: fetch granted this cycle.
- `if_rvalid` out 1: `if_rdata` valid.
- `if_rdata` out DATA_W: fetch read data.
- `dm_req` in 1: data request.
- `dm_w_en` in 4: byte enables; 0 means read.
- `dm_addr` in ADDR_W: data address.
- `dm_write_data` in DATA_W: data to write.
- `dm_gnt` out 1: data request granted.
- `dm_rvalid` out 1: `dm_rdata` valid.
- `dm_rdata` out DATA_W: data read result.
- `mem_addr` out ADDR_W: to SRAM `address`.
- `mem_w_en` out 4: to SRAM `w_en`.
- `mem_write_data` out DATA_W: to SRAM `write_data`.
- `mem_read_data` in DATA_W: from SRAM `read_data`.

## Operation

- Two states: BOOT (reset state) and RUN. `boot_busy` = (state == BOOT).
- **BOOT**
  - Only the loader is served. `ld_req` drives `mem_addr=ld_addr`, `mem_w_en=4'hF`, `mem_write_data=ld_wdata`.
  - `if_gnt` and `dm_gnt` are held 0; requests are ignored and not queued.
  - `ld_done` moves to RUN at the next edge. If `ld_req` is asserted in the same cycle, that write still completes.
- **RUN**
  - At most one grant per cycle; grants are combinational from requests and registered state.
  - Default priority: dm over if.
  - If `starve_cnt >= STARVE_LIMIT`, if has priority over dm for that cycle.
  - `ld_req` and `ld_done` are ignored.
- **Starvation counter** (`starve_cnt`, 4 bits, saturating)
  - Increments when `if_req && !if_gnt` in RUN.
  - Clears to 0 when `if_gnt` is high or `if_req` is low.
- **Idle cycle** (no grant): `mem_w_en=0`, `mem_addr=0`, `mem_write_data=0`.
- **Read return**
  - A registered owner tag (NONE/IF/DM) records each granted read, i.e. `if_gnt`, or `dm_gnt` with `dm_w_en==0`.
  - Next cycle: `if_rvalid` or `dm_rvalid` is set from the tag.
  - `if_rdata` and `dm_rdata` both pass `mem_read_data` through combinationally; only the rvalid signals qualify it.
  - Writes produce no rvalid.
- **Requester contract:** a requester holds req/addr/data stable until it sees its grant. The arbiter keeps no request buffer.

## Timing

- **Reset values:**
  - state BOOT, `boot_busy=1`;
  - `starve_cnt=0`, owner tag NONE;
  - `if_rvalid=dm_rvalid=0`, `if_gnt=dm_gnt=0`;
  - `mem_*` outputs 0.
- Grant to SRAM sample: same cycle. Read latency: grant at cycle N, rvalid and data at cycle N+1.
- Back-to-back grants are allowed every cycle. Rvalids of consecutive reads appear in consecutive cycles, in grant order.
- Reset asserted mid-operation: owner tag and rvalids clear immediately (asynchronously). An in-flight read is dropped with no rvalid.
- Simultaneous `if_req` and `dm_req` with `starve_cnt == STARVE_LIMIT-1`: dm wins, count reaches LIMIT, and if wins the following cycle.
- `ld_done` asserted in RUN has no effect. Reset is the only way back to BOOT.

## Structure

- Shared package `mem_arb_pkg`:
  - `arb_state_t` {BOOT, RUN};
  - `owner_t` {OWN_NONE, OWN_IF, OWN_DM};
  - default `ADDR_W`/`DATA_W` constants.
- Single module. Grant logic, address/data muxing, the state register and the counter all live in `mem_port_arbiter`. No sub-module is needed.

## Test plan

- **Boot load:** reset, then loader writes 0x00000013 to 0x0000 and 0x00100073 to 0x0004, then `ld_done` → `mem_w_en=4'hF` on both writes, `boot_busy` falls next edge, `if_gnt`=0 throughout BOOT despite `if_req=1`.
- **Fetch read:** in RUN, `if_req` at 0x0004 alone → `if_gnt` same cycle, `if_rvalid=1` next cycle with `if_rdata=0x00100073`, `dm_rvalid=0`.
- **Contention and starvation:** `dm_req` reads and `if_req` held continuously, `STARVE_LIMIT=4` → dm granted 4 cycles, fetch granted the 5th, `starve_cnt` clears, then dm resumes.
- **Data write then read:** `dm_w_en=4'b0011` data 0xAAAA5555 at 0x0010, then read 0x0010 → `mem_w_en=4'b0011` on the write, no rvalid for the write, `dm_rvalid` one cycle after the read grant with the low halfword 0x5555.
- **Reset mid-read:** grant a fetch, then assert `rst` before the next edge → `if_rvalid` stays 0, state returns to BOOT, `boot_busy=1`.
- **Simultaneous `ld_req` and `ld_done`:** write to 0x0020 lands, `boot_busy` drops the next cycle, and a later `ld_req` in RUN produces no SRAM write.
